// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/MEM/MULDIV requesters, the hazard unit stall,
// and the register file write port that regfile_wb_arbiter drives.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              WbStall;

    logic              AluValid;
    logic [ADDR_W-1:0] AluReg;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;

    logic              MemValid;
    logic [ADDR_W-1:0] MemReg;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;

    logic              MdValid;
    logic [ADDR_W-1:0] MdReg;
    logic [DATA_W-1:0] MdData;
    logic              MdReady;

    logic              Write1;
    logic [ADDR_W-1:0] WriteReg1;
    logic [DATA_W-1:0] WriteData1;
    logic [CNT_W-1:0]  WbCount;

    // Arbiter side
    modport slave (
        input  WbStall,
        input  AluValid, AluReg, AluData,
        input  MemValid, MemReg, MemData,
        input  MdValid,  MdReg,  MdData,
        output AluReady, MemReady, MdReady,
        output Write1, WriteReg1, WriteData1, WbCount
    );

    // Requester / register-file side
    modport master (
        output WbStall,
        output AluValid, AluReg, AluData,
        output MemValid, MemReg, MemData,
        output MdValid,  MdReg,  MdData,
        input  AluReady, MemReady, MdReady,
        input  Write1, WriteReg1, WriteData1, WbCount
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port among ALU, MEM and MULDIV writebacks.
// Define WB_RR_EN for round-robin arbitration; otherwise fixed priority ALU > MEM > MD.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MEM = 2'd1,
        REQ_MD  = 2'd2
    } reqSel_e;

    logic [2:0]        validVec;
    logic [2:0]        grantVec;
    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;

    assign validVec = {bus.MdValid, bus.MemValid, bus.AluValid};

`ifdef WB_RR_EN
    reqSel_e ptr;
    reqSel_e ptrNext;
    logic [5:0] dblVec;
    logic [2:0] lowVec;

    // Rotate so the pointer's requester sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grantVec = '0;
        dblVec   = {validVec, validVec};
        lowVec   = '0;
        if (RESET && !bus.WbStall) begin
            lowVec   = 3'(dblVec >> ptr);
            lowVec   = lowVec & (~lowVec + 3'd1);
            grantVec = 3'(({lowVec, lowVec} << ptr) >> 3);
        end
    end

    always_comb begin
        ptrNext = ptr;
        case (grantVec)
            3'b001:  ptrNext = REQ_MEM;
            3'b010:  ptrNext = REQ_MD;
            3'b100:  ptrNext = REQ_ALU;
            default: ptrNext = ptr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) ptr <= REQ_ALU;
        else        ptr <= ptrNext;
    end
`else
    always_comb begin
        grantVec = '0;
        if (RESET && !bus.WbStall) begin
            grantVec[0] = validVec[0];
            grantVec[1] = validVec[1] & ~validVec[0];
            grantVec[2] = validVec[2] & ~validVec[1] & ~validVec[0];
        end
    end
`endif

    assign bus.AluReady = grantVec[0];
    assign bus.MemReady = grantVec[1];
    assign bus.MdReady  = grantVec[2];

    always_comb begin
        selReg  = '0;
        selData = '0;
        case (grantVec)
            3'b001: begin selReg = bus.AluReg; selData = bus.AluData; end
            3'b010: begin selReg = bus.MemReg; selData = bus.MemData; end
            3'b100: begin selReg = bus.MdReg;  selData = bus.MdData;  end
            default: ;
        endcase
    end

    // Register 0 is hardwired, so a grant to it completes the handshake but never writes or counts.
    always_ff @(posedge CLK) begin
        // NOTE: synchronous reset and non-blocking assignments keep every state update on the same edge.
        if (!RESET) begin
            bus.Write1     <= 1'b0;
            bus.WriteReg1  <= '0;
            bus.WriteData1 <= '0;
            bus.WbCount    <= '0;
        end else if (|grantVec) begin
            bus.Write1     <= (selReg != '0);
            bus.WriteReg1  <= selReg;
            bus.WriteData1 <= selData;
            if ((selReg != '0) && (bus.WbCount != '1))
                bus.WbCount <= bus.WbCount + 1'b1;
        end else begin
            bus.Write1 <= 1'b0;
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (Write1/WriteReg1/WriteData1) among three writeback requesters: ALU, MEM (load return) and MULDIV.
- Each requester uses a valid/ready handshake. The winner's write is registered and driven to the register file one cycle later.
- Sits between the execute/memory stages and the register file.
- Also provides a global stall input from the hazard unit and a committed-write counter for debug.

Parameters:
- DATA_W, 32, data width of a writeback.
- ADDR_W, 5, register index width.
- CNT_W, 16, width of the committed-write counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  reset, synchronous and active-low; sampled only at posedge CLK.
- WbStall  input  1  when 1, no grants are issued this cycle.
- AluValid / MemValid / MdValid  input  1 each  requester has a pending writeback.
- AluReg / MemReg / MdReg  input  ADDR_W each  destination register.
- AluData / MemData / MdData  input  DATA_W each  writeback value.
- AluReady / MemReady / MdReady  output  1 each  combinational grant; transfer occurs when Valid&Ready at posedge.
- Write1  output  1  registered write enable to the register file.
- WriteReg1  output  ADDR_W  registered destination register.
- WriteData1  output  DATA_W  registered write data.
- WbCount  output  CNT_W  saturating count of writes driven with Write1=1.

Behaviour:
- Reset (RESET=0 at posedge): Write1=0, WriteReg1=0, WriteData1=0, WbCount=0, priority pointer=ALU. Ready outputs are 0 while RESET=0.
- Reset mid-operation: any grant in the reset cycle is discarded; no write appears on the following cycle.
- Requester contract: once Valid=1, Reg and Data stay stable until the handshake completes. Valid does not drop before Ready.
- Ready generation (combinational):
  - At most one Ready is 1 per cycle, and only when WbStall=0 and that requester's Valid=1.
  - The winner is chosen by the priority order (see Optional Feature).
  - Ready never depends on Ready.
- Transfer (cycle N): at posedge ending cycle N, the winner's Reg/Data are captured. In cycle N+1, Write1=1, WriteReg1=Reg, WriteData1=Data. Latency is one cycle.
- No transfer in cycle N: in cycle N+1, Write1=0. WriteReg1 and WriteData1 hold their last values.
- Register 0: a grant with Reg=0 completes the handshake (Ready=1), but Write1 stays 0 in cycle N+1 and WbCount does not increment. WriteReg1/WriteData1 still update.
- WbCount: increments by 1 on each cycle Write1=1. It saturates at all-ones (2^CNT_W-1) and does not wrap.
- WbStall=1: all Ready=0, the pointer is unchanged, and Write1=0 next cycle. Requests stay pending.
- Back-to-back: a requester keeping Valid=1 with new Reg/Data after each handshake may transfer every cycle it wins.
- Two requesters targeting the same register in consecutive cycles: both writes go out in grant order; the later grant's value wins in the register file.

Optional Feature:
- Macro: WB_RR_EN.
- Defined: round-robin arbitration.
  - The pointer names the highest-priority requester, initialised to ALU.
  - Search order is pointer, pointer+1, pointer+2, over the ring ALU→MEM→MD→ALU.
  - After a transfer to requester i, the pointer moves to i+1 (mod 3). With no transfer, the pointer holds.
  - Guarantee: a continuously valid requester is granted within 3 unstalled cycles.
- Undefined: fixed priority ALU > MEM > MD. The pointer logic is absent, and a lower requester can starve.

Test Plan:
1. Reset, then AluValid=1, AluReg=5, AluData=0xDEADBEEF with the others idle → AluReady=1 in that cycle; next cycle Write1=1, WriteReg1=5, WriteData1=0xDEADBEEF, WbCount=1.
2. All three valid continuously (Reg 1/2/3), WB_RR_EN defined → grant order ALU, MEM, MD, ALU…; Write1 sequence writes 1,2,3,1. With WB_RR_EN undefined → ALU granted every cycle; MemReady=0 and MdReady=0 throughout.
3. MemValid=1, MemReg=0, MemData=0x1234 → MemReady=1; next cycle Write1=0 and WbCount unchanged.
4. AluValid=1 with WbStall=1 for 3 cycles, then WbStall=0 → AluReady=0 and Write1=0 during the stall; grant in the first unstalled cycle; Write1=1 one cycle later.
5. Grant to MD in cycle N, RESET=0 at the end of cycle N → cycle N+1 shows Write1=0, WbCount=0, pointer=ALU (next simultaneous request is granted to ALU).
6. With CNT_W=4, perform 17 writes to nonzero registers → WbCount reads 15 after the 15th write and stays 15.
